// File: rtl/bcd_7seg_scanner.sv
// bcd_7seg_scanner: time-multiplexed driver for a 4-digit common-anode
// seven-segment display, fed with packed BCD digits.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bcd_in     {d3,d2,d1,d0} BCD digits, d3 is the most significant digit
//   load       capture bcd_in into the shadow register this cycle
//   seg        {g,f,e,d,c,b,a}, active-low segment drive
//   an         digit anodes, active-low; an[i] drives digit i
//   digit_idx  index of the digit currently being driven
//   bad_digit  high while the driven digit holds a nibble greater than 9
//
// Each digit is driven for REFRESH_CNT cycles, followed by one all-off
// blanking cycle so the previous digit cannot ghost onto the next anode.
// All outputs are registered and lag the scan state by one cycle.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When defined, digits above the most significant non-zero digit are
//   shown blank (digit 0 is always shown). When undefined, every digit
//   is decoded.

module bcd_7seg_scanner #(
  parameter int REFRESH_CNT = 50000,
  parameter int DIV_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic        load,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx,
  output logic        bad_digit
);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam logic [DIV_W-1:0] TC =
    DIV_W'(REFRESH_CNT - 1);

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [3:0] AN_OFF   = 4'hF;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] presc_nxt;
  logic [1:0]       ptr;
  logic [1:0]       ptr_nxt;
  logic [3:0][3:0]  shadow;

  logic [6:0]       seg_nxt;
  logic [3:0]       an_nxt;
  logic [1:0]       idx_nxt;
  logic             bad_nxt;

  logic [3:0]       nib;
  logic [6:0]       nib_seg;
  logic             nib_bad;
  logic             tc;
  logic             lz_blank;

  function automatic logic [6:0] decode(
    input logic [3:0] d
  );
    logic [6:0] s;
    s = SEG_DASH;
    case (d)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd2: s = 7'h24;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd6: s = 7'h02;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= bcd_in;
    end
  end

  assign nib     = shadow[ptr];
  assign nib_seg = decode(nib);
  assign nib_bad = (nib > 4'd9);
  assign tc      = (presc == TC);

`ifdef LEADING_ZERO_BLANK_EN
  // zero_from[i]: every shadow digit at position i and above is zero.
  logic [3:0] zero_from;

  always_comb begin
    zero_from[3] = (shadow[3] == 4'd0);
    zero_from[2] = zero_from[3] &&
                   (shadow[2] == 4'd0);
    zero_from[1] = zero_from[2] &&
                   (shadow[1] == 4'd0);
    zero_from[0] = zero_from[1] &&
                   (shadow[0] == 4'd0);
  end

  assign lz_blank = (ptr != 2'd0) &&
                    zero_from[ptr];
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    ptr_nxt   = ptr;
    seg_nxt   = SEG_OFF;
    an_nxt    = AN_OFF;
    idx_nxt   = ptr;
    bad_nxt   = 1'b0;

    unique case (state)
      BLANK: begin
        state_nxt = DRIVE;
        presc_nxt = '0;
      end
      DRIVE: begin
        an_nxt  = ~(4'b0001 << ptr);
        seg_nxt = lz_blank ? SEG_OFF
                           : nib_seg;
        bad_nxt = nib_bad;
        if (tc) begin
          presc_nxt = '0;
          ptr_nxt   = ptr + 2'd1;
          state_nxt = BLANK;
        end else begin
          presc_nxt = presc + 1'b1;
        end
      end
      default: begin
        state_nxt = BLANK;
        presc_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
      presc <= '0;
      ptr   <= 2'd0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Outputs are derived from the pre-edge scan state, so a load seen
  // at one edge reaches seg at the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg       <= SEG_OFF;
      an        <= AN_OFF;
      digit_idx <= 2'd0;
      bad_digit <= 1'b0;
    end else begin
      seg       <= seg_nxt;
      an        <= an_nxt;
      digit_idx <= idx_nxt;
      bad_digit <= bad_nxt;
    end
  end

endmodule
